// File: rtl/serial_subtractor.sv
// ============================================================================
// serial_subtractor
// ----------------------------------------------------------------------------
// Bit-serial W-bit subtractor computing diff = a - b - b_in (mod 2^W), one
// bit per clock, LSB first. A single borrow cell plus three shift registers
// stand in for a parallel W-bit subtractor. The caller talks to it through a
// start/busy/done handshake. One operation occupies W+1 cycles: W BUSY
// cycles and one DONE cycle.
//
// Parameters
//   W       operand/result width in bits (W >= 2), default 16
//
// Ports
//   clk     in   1  rising-edge clock
//   rst_n   in   1  asynchronous active-low reset
//   start   in   1  request; only sampled while busy == 0
//   a       in   W  minuend, sampled with start
//   b       in   W  subtrahend, sampled with start
//   b_in    in   1  borrow-in, sampled with start
//   busy    out  1  high from the cycle after start until done drops
//   done    out  1  one-cycle pulse; diff/b_out (and ovf) valid from here on
//   diff    out  W  a - b - b_in modulo 2^W, held until next completion
//   b_out   out  1  borrow-out: 1 iff a < b + b_in (unsigned)
//   ovf     out  1  signed overflow of the subtraction (optional, see below)
//
// Configuration
//   SERIAL_SUB_OVF_EN  when defined, adds the ovf output. It flags signed
//                      two's-complement overflow: the operands have different
//                      signs and the result sign differs from the minuend.
//                      It is registered and held alongside diff. When the
//                      macro is undefined, the port and its logic are absent.
// ============================================================================
module serial_subtractor #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         b_in,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] diff,
    output logic         b_out
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic         ovf
`endif
);

    localparam int CNT_W = (W > 1) ? $clog2(W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(W - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    // Operand shift registers. They are consumed from bit 0 and shift right,
    // so sa[0]/sb[0] always hold the bit currently being processed.
    logic [W-1:0]     sa;
    logic [W-1:0]     sb;
    // Result shift register. Each new bit enters at the MSB, so after W
    // shifts the LSB-first stream has landed in natural bit order.
    logic [W-1:0]     sd;
    logic             br;
    logic [CNT_W-1:0] cnt;

    logic             d_bit;
    logic             br_next;
    logic             last_bit;
    logic [W-1:0]     sd_next;

    // ------------------------------------------------------------------
    // Single-bit full subtractor cell
    // ------------------------------------------------------------------
    function automatic logic sub_diff(input logic x, input logic y, input logic bw);
        return x ^ y ^ bw;
    endfunction

    // A borrow leaves the cell when y beats x outright, or when x == y and a
    // borrow was already pending.
    function automatic logic sub_borrow(input logic x, input logic y, input logic bw);
        return (~x & y) | (~(x ^ y) & bw);
    endfunction

    assign d_bit    = sub_diff(sa[0], sb[0], br);
    assign br_next  = sub_borrow(sa[0], sb[0], br);
    assign sd_next  = {d_bit, sd[W-1:1]};
    assign last_bit = (state == BUSY) && (cnt == CNT_LAST);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (last_bit) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                // The DONE state lasts exactly one cycle, with no way to
                // stall. A start seen here is dropped; the caller re-issues
                // it once busy is low.
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        busy = (state != IDLE);
        done = (state == DONE);
    end

    // ------------------------------------------------------------------
    // Serial datapath
    // ------------------------------------------------------------------
    // Reset clears the working registers as well, so an aborted operation
    // leaves no stale partial result behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sa    <= '0;
            sb    <= '0;
            sd    <= '0;
            br    <= 1'b0;
            cnt   <= '0;
            diff  <= '0;
            b_out <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        sa  <= a;
                        sb  <= b;
                        br  <= b_in;
                        cnt <= '0;
                    end
                end
                BUSY: begin
                    sd <= sd_next;
                    sa <= sa >> 1;
                    sb <= sb >> 1;
                    br <= br_next;
                    if (last_bit) begin
                        // Publish the result in the same cycle as its final
                        // bit, so that diff is already valid when done rises.
                        cnt   <= '0;
                        diff  <= sd_next;
                        b_out <= br_next;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef SERIAL_SUB_OVF_EN
    // ------------------------------------------------------------------
    // Signed overflow flag
    // ------------------------------------------------------------------
    // On the last bit, sa[0]/sb[0] hold the original sign bits of a and b,
    // and d_bit is the sign bit of the result. No separate copy of the
    // operand signs is needed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if (last_bit) begin
            ovf <= (sa[0] ^ sb[0]) & (d_bit ^ sa[0]);
        end
    end
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor (W = 16). Expected results are
// pushed to a scoreboard queue when an operation is launched. They are
// popped and compared when the DUT raises done.
module tb_serial_subtractor;

    localparam int W = 16;

    typedef struct packed {
        logic [W-1:0] diff;
        logic         b_out;
        logic         ovf;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         b_in;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         b_out;
`ifdef SERIAL_SUB_OVF_EN
    logic         ovf;
`endif

    int   compared   = 0;
    int   mismatched = 0;
    int   done_cnt   = 0;
    exp_t sb[$];

    serial_subtractor #(.W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .b_in  (b_in),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .b_out (b_out)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    always #5 clk = ~clk;

    // Count the done pulses independently of the stimulus flow.
    always @(negedge clk) begin
        if (done) done_cnt++;
    end

    // Reference model: a plain (W+1)-bit subtraction.
    function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bi);
        logic [W:0] r;
        exp_t e;
        r       = {1'b0, av} - {1'b0, bv} - {{W{1'b0}}, bi};
        e.diff  = r[W-1:0];
        e.b_out = r[W];
        e.ovf   = (av[W-1] != bv[W-1]) && (r[W-1] != av[W-1]);
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Compare the current outputs against the oldest scoreboard entry.
    task automatic pop_check(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check({tag, "_diff"}, 32'(diff), 32'(e.diff));
            check({tag, "_bout"}, 32'(b_out), 32'(e.b_out));
`ifdef SERIAL_SUB_OVF_EN
            check({tag, "_ovf"}, 32'(ovf), 32'(e.ovf));
`endif
        end
    endtask

    // Launch one operation (called at a negedge). Inputs are scrambled while
    // it runs. The task then waits for done and checks the result, the
    // latency and the busy window.
    task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bi, input string tag);
        int  lat;
        int  busy_cycles;
        bit  seen;
        a = av; b = bv; b_in = bi; start = 1'b1;
        sb.push_back(model(av, bv, bi));
        @(negedge clk);
        start = 1'b0;
        lat = 1; busy_cycles = 0; seen = 0;
        while (!seen && lat <= W + 10) begin
            if (busy) busy_cycles++;
            if (done) begin
                seen = 1;
                pop_check(tag);
                check({tag, "_latency"}, 32'(lat), 32'(W + 1));
            end else begin
                a = W'($urandom); b = W'($urandom); b_in = 1'($urandom);
                @(negedge clk);
                lat++;
            end
        end
        if (!seen) begin
            check({tag, "_timeout"}, 32'(seen), 32'd1);
            if (sb.size() != 0) void'(sb.pop_back());
        end
        @(negedge clk);
        check({tag, "_busy_cycles"}, 32'(busy_cycles), 32'(W + 1));
        check({tag, "_busy_after"}, 32'(busy), 32'd0);
        check({tag, "_done_after"}, 32'(done), 32'd0);
    endtask

    initial begin
        int base;
        bit got;

        // Reset state
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; b_in = 1'b0;
        #3;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_diff", 32'(diff), 32'd0);
        check("rst_bout", 32'(b_out), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic subtraction
        do_op(16'h1234, 16'h0034, 1'b0, "t1");
        check("t1_diff_const", 32'(diff), 32'h1200);
        check("t1_bout_const", 32'(b_out), 32'd0);

        // Wrap-around
        do_op(16'h0000, 16'h0001, 1'b0, "t2");
        check("t2_diff_const", 32'(diff), 32'hFFFF);
        check("t2_bout_const", 32'(b_out), 32'd1);
`ifdef SERIAL_SUB_OVF_EN
        check("t2_ovf_const", 32'(ovf), 32'd0);
`endif

        // Borrow-in
        do_op(16'h0005, 16'h0003, 1'b1, "t3a");
        check("t3a_diff_const", 32'(diff), 32'h0001);
        check("t3a_bout_const", 32'(b_out), 32'd0);
        do_op(16'h0003, 16'h0003, 1'b1, "t3b");
        check("t3b_diff_const", 32'(diff), 32'hFFFF);
        check("t3b_bout_const", 32'(b_out), 32'd1);

        // Signed overflow corner
        do_op(16'h8000, 16'h0001, 1'b0, "t6");
        check("t6_diff_const", 32'(diff), 32'h7FFF);
        check("t6_bout_const", 32'(b_out), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
        check("t6_ovf_const", 32'(ovf), 32'd1);
`endif

        // Extremes and random operands
        do_op(16'hFFFF, 16'hFFFF, 1'b0, "ext0");
        do_op(16'hFFFF, 16'h0000, 1'b1, "ext1");
        for (int i = 0; i < 4; i++) begin
            do_op(W'($urandom), W'($urandom), 1'($urandom), "rnd");
        end

        // start held high with new operands every cycle. Only edges 0 and
        // 18 may sample; the op launched at edge 18 begins just after done
        // has dropped.
        base = done_cnt;
        for (int i = 0; i < 30; i++) begin
            if (done) pop_check("t4_op");
            a = W'($urandom); b = W'($urandom); b_in = 1'($urandom); start = 1'b1;
            if (i == 0 || i == 18) sb.push_back(model(a, b, b_in));
            if (i == 17) check("t4_busy_in_done", 32'(busy), 32'd1);
            @(negedge clk);
        end
        start = 1'b0;
        got = 0;
        for (int k = 0; k < 40 && !got; k++) begin
            if (done) begin
                got = 1;
                pop_check("t4_op2");
            end else begin
                @(negedge clk);
            end
        end
        if (!got) check("t4_timeout", 32'(got), 32'd1);
        @(negedge clk);
        #1;
        check("t4_done_pulses", 32'(done_cnt - base), 32'd2);
        check("t4_sb_drained", 32'(sb.size()), 32'd0);

        // Asynchronous reset in the middle of BUSY
        a = 16'h4321; b = 16'h0101; b_in = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        check("t5_busy_pre", 32'(busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_done", 32'(done), 32'd0);
        check("t5_diff", 32'(diff), 32'd0);
        check("t5_bout", 32'(b_out), 32'd0);
        base = done_cnt;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        #1;
        check("t5_no_done", 32'(done_cnt - base), 32'd0);
        @(negedge clk);
        do_op(16'hA5A5, 16'h5A5A, 1'b1, "t5_after");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
